// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
// A shared prescaler produces a periodic tick. Each channel runs as OFF, ON,
// BLINK or DIM_BLINK, where DIM_BLINK gates the blink with a shared PWM counter.
module led_pattern_gen #(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 125000,
    parameter int PERIOD_W = 12,
    parameter int PWM_W    = 8,
    parameter int DEF_HALF = 500,
    parameter int DEF_MODE = 2,
    parameter int SEL_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half_period,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic                cfg_err,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led
);
    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PWM_W-1:0] DEF_DUTY = PWM_W'(1) << (PWM_W - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_DIM   = 2'd3
    } mode_e;

    localparam mode_e DEF_MODE_E = mode_e'(2'(DEF_MODE));

    logic [PRE_W-1:0]    presc_reg;
    logic                tick_reg;
    logic [PWM_W-1:0]    pwm_cnt_reg;
    logic                cfg_err_reg;
    logic [NUM_LEDS-1:0] wr_hit;

    // Shared prescaler: wraps every TICK_DIV clocks and flags the wrap for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
        end else if (presc_reg == PRE_LAST) begin
            presc_reg <= '0;
            tick_reg  <= 1'b1;
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
            tick_reg  <= 1'b0;
        end
    end

    // Free-running PWM counter shared by every dimmed channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
        end
    end

    // A write that matches no channel is out of range; flag it on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_we && (wr_hit == '0);
        end
    end

    assign tick    = tick_reg;
    assign cfg_err = cfg_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            mode_e               mode_reg;
            logic [PERIOD_W-1:0] half_reg;
            logic [PWM_W-1:0]    duty_reg;
            logic [PERIOD_W-1:0] tick_cnt_reg;
            logic                phase_reg;
            logic                led_reg;
            logic [PERIOD_W-1:0] half_last;
            logic                blinking;
            logic                led_next;

            // Decoding per channel keeps the out-of-range check free of constant compares.
            assign wr_hit[gi] = cfg_we && (cfg_sel == SEL_W'(gi));
            // A zero half-period behaves like one tick per half-cycle.
            assign half_last  = (half_reg == '0) ? '0 : (half_reg - PERIOD_W'(1));
            assign blinking   = (mode_reg == MODE_BLINK) || (mode_reg == MODE_DIM);

            // Channel config and blink engine; a write overrides a coincident tick.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mode_reg     <= DEF_MODE_E;
                    half_reg     <= PERIOD_W'(DEF_HALF);
                    duty_reg     <= DEF_DUTY;
                    tick_cnt_reg <= '0;
                    phase_reg    <= 1'b0;
                end else if (wr_hit[gi]) begin
                    mode_reg     <= mode_e'(cfg_mode);
                    half_reg     <= cfg_half_period;
                    duty_reg     <= cfg_duty;
                    tick_cnt_reg <= '0;
                    phase_reg    <= 1'b1;
                end else if (tick_reg && blinking) begin
                    if (tick_cnt_reg == half_last) begin
                        tick_cnt_reg <= '0;
                        phase_reg    <= ~phase_reg;
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + PERIOD_W'(1);
                    end
                end
            end

            // Decode the LED level from the current channel state.
            always_comb begin
                led_next = 1'b0;
                case (mode_reg)
                    MODE_OFF:   led_next = 1'b0;
                    MODE_ON:    led_next = 1'b1;
                    MODE_BLINK: led_next = phase_reg;
                    MODE_DIM:   led_next = phase_reg && (pwm_cnt_reg < duty_reg);
                endcase
            end

            // Register the pin drive so the board sees a clean, glitch-free level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    led_reg <= 1'b0;
                end else begin
                    led_reg <= led_next;
                end
            end

            assign led[gi] = led_reg;
        end
    endgenerate

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed bench with a cycle-keyed scoreboard.
// The stimulus pushes expectations tagged with the post-reset cycle number;
// the monitor pops and compares them as it samples the DUT outputs.
module tb_led_pattern_gen;
    localparam int NL = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_we;
    logic [2:0]    cfg_sel;
    logic [1:0]    cfg_mode;
    logic [7:0]    cfg_half_period;
    logic [3:0]    cfg_duty;
    logic          cfg_err;
    logic          tick;
    logic [NL-1:0] led;

    led_pattern_gen #(
        .NUM_LEDS(NL),
        .TICK_DIV(4),
        .PERIOD_W(8),
        .PWM_W(4),
        .DEF_HALF(3),
        .DEF_MODE(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_mode(cfg_mode),
        .cfg_half_period(cfg_half_period),
        .cfg_duty(cfg_duty),
        .cfg_err(cfg_err),
        .tick(tick),
        .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NL-1:0] mask;
        logic [NL-1:0] led;
        logic          tick;
        logic          err;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   cyc          = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Rising edges since the last reset release; the scoreboard is keyed on it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Queue one expectation; tick is high on every 4th edge after release.
    task automatic push(input int c, input logic [NL-1:0] m, input logic [NL-1:0] l,
                        input logic e, input string n);
        exp_t x;
        x.cyc  = c;
        x.mask = m;
        x.led  = l & m;
        x.tick = (c != 0) && (c % 4 == 0);
        x.err  = e;
        x.name = n;
        sb.push_back(x);
    endtask

    // Default pattern after release: half=3 ticks, phase toggles on edges 13, 25, ...
    task automatic push_default();
        push(3,  '0, '0, 1'b0, "tick_before_first");
        push(4,  '0, '0, 1'b0, "tick_first");
        push(5,  '0, '0, 1'b0, "tick_one_cycle");
        push(8,  '0, '0, 1'b0, "tick_period");
        push(13, '1, '0, 1'b0, "default_dark");
        push(14, '1, '1, 1'b0, "default_rise");
        push(25, '1, '1, 1'b0, "default_hold");
        push(26, '1, '0, 1'b0, "default_fall");
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_cyc: reached cyc=%0d, required %0d", cyc, n);
        end
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [1:0] mode,
                             input logic [7:0] half, input logic [3:0] duty);
        cfg_we          = 1'b1;
        cfg_sel         = sel;
        cfg_mode        = mode;
        cfg_half_period = half;
        cfg_duty        = duty;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Monitor: samples after each falling clock edge and right after a reset drop.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                x = sb.pop_front();
                tests_run++;
                if (x.cyc != cyc) begin
                    tests_failed++;
                    $display("FAIL %s: expectation for cyc %0d never sampled (now cyc %0d)",
                             x.name, x.cyc, cyc);
                end else if (((led & x.mask) !== x.led) || (tick !== x.tick) || (cfg_err !== x.err)) begin
                    tests_failed++;
                    $display("FAIL %s cyc=%0d: got led=%b tick=%b err=%b, want led=%b (mask %b) tick=%b err=%b",
                             x.name, cyc, led, tick, cfg_err, x.led, x.mask, x.tick, x.err);
                end else begin
                    $display("ok   %s cyc=%0d led=%b tick=%b err=%b", x.name, cyc, led, tick, cfg_err);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        cfg_we          = 1'b0;
        cfg_sel         = '0;
        cfg_mode        = '0;
        cfg_half_period = '0;
        cfg_duty        = '0;

        // Reset and default blink pattern.
        push(0, '1, '0, 1'b0, "reset_hold");
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        push_default();
        push(37, '1, '0, 1'b0, "default_dark2");
        push(38, '1, '1, 1'b0, "default_rise2");

        // Mode set: writes land on edges 39, 40, 41 (41 coincides with a tick).
        wait_cyc(38);
        push(40, '1, 5'b11101, 1'b0, "ch1_off");
        push(42, '1, 5'b11101, 1'b0, "ch3_blink_start_lit");
        push(45, '1, 5'b11101, 1'b0, "ch3_hold");
        push(46, '1, 5'b10101, 1'b0, "ch3_toggle");
        push(49, '1, 5'b10101, 1'b0, "ch3_low");
        push(50, '1, 5'b01100, 1'b0, "ch2_on_stays");
        push(54, '1, 5'b00100, 1'b0, "ch3_period8");
        cfg_write(3'd1, 2'd0, 8'd3, 4'd8);
        cfg_write(3'd2, 2'd1, 8'd3, 4'd8);
        cfg_write(3'd3, 2'd2, 8'd1, 4'd8);

        // DIM_BLINK ch0 half=5 duty=4, written on edge 58.
        wait_cyc(57);
        for (int m = 59; m <= 101; m++)
            push(m, 5'b00001, (m inside {[65:68], [98:100]}) ? 5'b00001 : 5'b00000, 1'b0, "ch0_dim");
        cfg_write(3'd0, 2'd3, 8'd5, 4'd4);

        // Boundaries: ch4 half=0, ch1 duty=0, ch2 duty=15, written on edges 102..104.
        wait_cyc(101);
        for (int m = 105; m <= 128; m++) begin
            logic [NL-1:0] l;
            l    = '0;
            l[4] = (((m - 102) / 4) % 2) == 0;
            l[2] = !(m == 112 || m == 128);
            push(m, 5'b10110, l, 1'b0, "boundary_half0_duty0_duty15");
        end
        cfg_write(3'd4, 2'd2, 8'd0, 4'd8);
        cfg_write(3'd1, 2'd3, 8'd7, 4'd0);
        cfg_write(3'd2, 2'd3, 8'd7, 4'd15);

        // Write to ch0 on the edge that consumes a tick (edge 133).
        wait_cyc(132);
        push(134, 5'b00001, 5'b00001, 1'b0, "collision_lit");
        push(137, 5'b00001, 5'b00001, 1'b0, "collision_hold");
        push(138, 5'b00001, 5'b00000, 1'b0, "collision_toggle");
        cfg_write(3'd0, 2'd2, 8'd1, 4'd8);

        // Out-of-range selects 5 and 7 on edges 140 and 142.
        wait_cyc(139);
        push(140, 5'b00000, 5'b00000, 1'b1, "err_sel5");
        push(141, 5'b00011, 5'b00000, 1'b0, "err_clear_led_same");
        push(142, 5'b00011, 5'b00001, 1'b1, "err_sel7");
        cfg_write(3'd5, 2'd1, 8'd3, 4'd8);
        @(posedge clk);
        #1;
        cfg_write(3'd7, 2'd1, 8'd3, 4'd8);

        // Asynchronous reset between edges while ch0 is lit, then restart.
        wait_cyc(143);
        push(0, '1, '0, 1'b0, "async_reset_immediate");
        push_default();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_cyc(27);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        while (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            tests_run++;
            tests_failed++;
            $display("FAIL %s: expectation for cyc %0d never checked", x.name, x.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
